// File: rtl/vx_arb_pkg.sv
// Shared types and helpers for the weighted fair arbiter.
// Optional feature macro: VX_ARB_PERF_EN (per-requestor grant counters).
package vx_arb_pkg;

    localparam int unsigned VX_ARB_WEIGHT_BITS = 4;
    localparam int unsigned VX_ARB_PERF_BITS   = 32;

    typedef logic [VX_ARB_WEIGHT_BITS-1:0] credit_t;
    typedef logic [VX_ARB_PERF_BITS-1:0]   perf_ctr_t;

    // A programmed weight of zero still earns one grant per round.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/vx_arb_lsb_select.sv
// Lowest-set-bit selector: one-hot, binary index and any-set flag.
module vx_arb_lsb_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned LOG_N = 2
) (
    input  logic [N-1:0]     in_vec,
    output logic [N-1:0]     onehot,
    output logic [LOG_N-1:0] index,
    output logic             valid
);

    // Scan upward and keep only the first set bit.
    always_comb begin
        logic found;
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_vec[i] && !found) begin
                onehot[i] = 1'b1;
                index     = LOG_N'(i);
                found     = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/vx_weighted_fair_arbiter.sv
// Credit-based weighted round-robin arbiter with burst locking.
// Grant is combinational from registered credits/lock and the live requests.
// Optional feature macro: VX_ARB_PERF_EN adds perf_grants saturating counters.
module vx_weighted_fair_arbiter
    import vx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned WEIGHT_BITS  = VX_ARB_WEIGHT_BITS,
    parameter int unsigned LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int unsigned PERF_BITS    = VX_ARB_PERF_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             requests,
    input  logic [NUM_REQS*WEIGHT_BITS-1:0] weights,
    input  logic                            lock,
    output logic [LOG_NUM_REQS-1:0]         grant_index,
    output logic [NUM_REQS-1:0]             grant_onehot,
    output logic                            grant_valid,
    input  logic                            grant_ready,
`ifdef VX_ARB_PERF_EN
    output logic [NUM_REQS*PERF_BITS-1:0]   perf_grants,
`endif
    output logic                            round_start
);

    logic [WEIGHT_BITS-1:0]  credits_q [NUM_REQS];
    logic [WEIGHT_BITS-1:0]  credits_d [NUM_REQS];
    logic [WEIGHT_BITS-1:0]  eff_w     [NUM_REQS];
    logic                    locked_q, locked_d;
    logic [LOG_NUM_REQS-1:0] locked_idx_q, locked_idx_d;

    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] qual;
    logic [NUM_REQS-1:0] sel_vec;
    logic                hold;
    logic                req_any;
    logic                fire;

    // Qualification: a locked burst overrides everything, otherwise
    // requestors with credit left, otherwise everyone (new round).
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            eff_w[i]    = WEIGHT_BITS'(eff_weight(32'(weights[i*WEIGHT_BITS +: WEIGHT_BITS])));
            eligible[i] = requests[i] && (credits_q[i] != '0);
        end
        req_any     = |requests;
        hold        = locked_q && requests[locked_idx_q];
        round_start = req_any && !hold && !(|eligible);
        qual        = round_start ? requests : eligible;
        sel_vec     = qual;
        if (hold) begin
            sel_vec               = '0;
            sel_vec[locked_idx_q] = 1'b1;
        end
    end

    vx_arb_lsb_select #(
        .N     (NUM_REQS),
        .LOG_N (LOG_NUM_REQS)
    ) u_sel (
        .in_vec (sel_vec),
        .onehot (grant_onehot),
        .index  (grant_index),
        .valid  (grant_valid)
    );

    assign fire = grant_valid && grant_ready;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_credit
        // Reload on round start (winner pays one), else winner pays one; hold beats are free.
        always_comb begin
            credits_d[gi] = credits_q[gi];
            if (fire && !hold) begin
                if (round_start) begin
                    if (!requests[gi])
                        credits_d[gi] = '0;
                    else if (grant_onehot[gi])
                        credits_d[gi] = eff_w[gi] - WEIGHT_BITS'(1);
                    else
                        credits_d[gi] = eff_w[gi];
                end else if (grant_onehot[gi]) begin
                    credits_d[gi] = credits_q[gi] - WEIGHT_BITS'(1);
                end
            end
        end

        // Per-requestor credit register.
        always_ff @(posedge clk) begin
            if (reset)
                credits_q[gi] <= '0;
            else
                credits_q[gi] <= credits_d[gi];
        end
    end

    // Lock is captured on every accepted beat together with the winner.
    always_comb begin
        locked_d     = locked_q;
        locked_idx_d = locked_idx_q;
        if (fire) begin
            locked_d     = lock;
            locked_idx_d = grant_index;
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q     <= 1'b0;
            locked_idx_q <= '0;
        end else begin
            locked_q     <= locked_d;
            locked_idx_q <= locked_idx_d;
        end
    end

`ifdef VX_ARB_PERF_EN
    logic [PERF_BITS-1:0] perf_q [NUM_REQS];
    logic [PERF_BITS-1:0] perf_d [NUM_REQS];

    for (genvar gp = 0; gp < NUM_REQS; gp++) begin : g_perf
        // Saturating count of accepted beats, burst beats included.
        always_comb begin
            perf_d[gp] = perf_q[gp];
            if (fire && grant_onehot[gp] && (perf_q[gp] != '1))
                perf_d[gp] = perf_q[gp] + PERF_BITS'(1);
        end

        // Counter register.
        always_ff @(posedge clk) begin
            if (reset)
                perf_q[gp] <= '0;
            else
                perf_q[gp] <= perf_d[gp];
        end

        assign perf_grants[gp*PERF_BITS +: PERF_BITS] = perf_q[gp];
    end
`endif

endmodule

// File: tb/tb_vx_weighted_fair_arbiter.sv
// Self-checking bench: per-cycle model comparison plus literal grant sequences.
module tb_vx_weighted_fair_arbiter;

    localparam int N  = 4;
    localparam int WB = 4;
    localparam int LN = 2;
    localparam int PB = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      requests = '0;
    logic [N*WB-1:0]   weights = 16'h1111;
    logic              lock = 1'b0;
    logic              grant_ready = 1'b1;
    logic [LN-1:0]     grant_index;
    logic [N-1:0]      grant_onehot;
    logic              grant_valid;
    logic              round_start;
`ifdef VX_ARB_PERF_EN
    logic [N*PB-1:0]   perf_grants;
`endif

    vx_weighted_fair_arbiter #(
        .NUM_REQS     (N),
        .WEIGHT_BITS  (WB),
        .LOG_NUM_REQS (LN),
        .PERF_BITS    (PB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .requests     (requests),
        .weights      (weights),
        .lock         (lock),
        .grant_index  (grant_index),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
`ifdef VX_ARB_PERF_EN
        .perf_grants  (perf_grants),
`endif
        .round_start  (round_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: credits per lane, lock flag/owner, grant counts.
    int     m_cred [N];
    bit     m_lk;
    int     m_lki;
    longint m_perf [N];
    int     n_cred [N];
    bit     n_lk;
    int     n_lki;
    longint n_perf [N];
    bit     armed = 1'b0;

    function automatic int effw(input int i);
        int w;
        w = int'(weights[i*WB +: WB]);
        return (w == 0) ? 1 : w;
    endfunction

    // Predict outputs from model state, compare, and prepare next model state.
    always @(negedge clk) begin
        bit hold, rs, v, fire;
        int g;
        hold = m_lk && requests[m_lki];
        v    = |requests;
        rs   = 1'b0;
        g    = -1;
        if (hold) begin
            g = m_lki;
        end else begin
            for (int i = 0; i < N; i++)
                if (requests[i] && m_cred[i] > 0 && g < 0) g = i;
            if (g < 0 && v) begin
                rs = 1'b1;
                for (int i = 0; i < N; i++)
                    if (requests[i] && g < 0) g = i;
            end
        end
        if (armed) begin
            check("grant_valid", grant_valid, v);
            check("grant_index", grant_index, v ? g : 0);
            check("grant_onehot", grant_onehot, v ? (1 << g) : 0);
            check("round_start", round_start, rs);
`ifdef VX_ARB_PERF_EN
            for (int i = 0; i < N; i++)
                check("perf_grants", perf_grants[i*PB +: PB], m_perf[i]);
`endif
        end
        n_lk  = m_lk;
        n_lki = m_lki;
        for (int i = 0; i < N; i++) begin
            n_cred[i] = m_cred[i];
            n_perf[i] = m_perf[i];
        end
        fire = v && grant_ready;
        if (reset) begin
            n_lk = 1'b0;
            n_lki = 0;
            for (int i = 0; i < N; i++) begin
                n_cred[i] = 0;
                n_perf[i] = 0;
            end
        end else if (fire) begin
            if (!hold) begin
                if (rs)
                    for (int i = 0; i < N; i++)
                        n_cred[i] = requests[i] ? effw(i) : 0;
                n_cred[g] = n_cred[g] - 1;
            end
            n_lk  = lock;
            n_lki = g;
            if (n_perf[g] < 64'hFFFF_FFFF) n_perf[g] = n_perf[g] + 1;
        end
    end

    always @(posedge clk) begin
        m_lk  = n_lk;
        m_lki = n_lki;
        for (int i = 0; i < N; i++) begin
            m_cred[i] = n_cred[i];
            m_perf[i] = n_perf[i];
        end
        if (reset) armed = 1'b1;
    end

    // One beat: inputs already driven; check literal expectation, advance a cycle.
    task automatic beat(input int exp_idx, input bit exp_rs, input string name);
        @(negedge clk);
        check({name, "_idx"}, grant_index, exp_idx);
        check({name, "_rs"}, round_start, exp_rs);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        requests = '0;
        lock     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            n_cred[i] = 0;
            n_perf[i] = 0;
        end
        n_lk  = 1'b0;
        n_lki = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_valid", grant_valid, 0);
        check("idle_onehot", grant_onehot, 0);
        check("idle_index", grant_index, 0);
        check("idle_rs", round_start, 0);
        @(posedge clk);
        #1;

        // Equal weights: plain round robin.
        weights = 16'h1111;
        requests = 4'b1111;
        beat(0, 1, "t1"); beat(1, 0, "t1"); beat(2, 0, "t1");
        beat(3, 0, "t1"); beat(0, 1, "t1");

        // w0=3, w1=1.
        do_reset();
        weights = 16'h1113;
        requests = 4'b0011;
        beat(0, 1, "t2"); beat(0, 0, "t2"); beat(0, 0, "t2"); beat(1, 0, "t2");
        beat(0, 1, "t2"); beat(0, 0, "t2"); beat(0, 0, "t2"); beat(1, 0, "t2");

        // Burst lock held for four beats, costing one credit.
        do_reset();
        weights = 16'h1111;
        requests = 4'b0011;
        lock = 1'b1;
        beat(0, 1, "t3"); beat(0, 0, "t3"); beat(0, 0, "t3");
        lock = 1'b0;
        beat(0, 0, "t3"); beat(1, 0, "t3"); beat(0, 1, "t3");

        // Back-pressure keeps the grant and state.
        do_reset();
        requests = 4'b0110;
        grant_ready = 1'b0;
        repeat (5) beat(1, 1, "t4_stall");
        grant_ready = 1'b1;
        beat(1, 1, "t4"); beat(2, 0, "t4");

        // Late requestor waits for the round; zero weight acts as one.
        do_reset();
        weights = 16'h1102;
        requests = 4'b0011;
        beat(0, 1, "t5");
        requests = 4'b0111;
        beat(0, 0, "t5"); beat(1, 0, "t5"); beat(0, 1, "t5");
        beat(0, 0, "t5"); beat(1, 0, "t5"); beat(2, 0, "t5"); beat(0, 1, "t5");

        // Reset during a locked burst.
        do_reset();
        weights = 16'h1111;
        requests = 4'b0011;
        lock = 1'b1;
        beat(0, 1, "t6"); beat(0, 0, "t6");
        reset = 1'b1;
        beat(0, 0, "t6_in_reset");
        reset = 1'b0;
        lock = 1'b0;
        @(negedge clk);
        check("t6_post_idx", grant_index, 0);
        check("t6_post_rs", round_start, 1);
`ifdef VX_ARB_PERF_EN
        for (int i = 0; i < N; i++)
            check("t6_perf_zero", perf_grants[i*PB +: PB], 0);
`endif
        @(posedge clk);
        #1;
        requests = 4'b0010;
        beat(1, 0, "t6");
        requests = '0;
        beat(0, 0, "t6_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
